console_dma_tx_scheduler: RTL

CONSOLE_DMA_TX_SCHEDULER -- requirements
Module: console_dma_tx_scheduler

---
 rtl/console_dma_tx_scheduler.sv | 87 ++++++++
 1 files changed

// File: rtl/console_dma_tx_scheduler.sv
// console_dma_tx_scheduler: packetizes console FIFO bytes into AXI-Stream bursts; define CONSOLE_DMA_TIMEOUT_FLUSH_EN for idle-timeout flush.
module console_dma_tx_scheduler #(
  parameter int BURST_MAX      = 64,
  parameter int THRESHOLD      = 32,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] fifo_count,
  output logic        fifo_rd_en,
  input  logic [7:0]  fifo_rd_data,
  input  logic        flush_req,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        busy,
  output logic [15:0] packets_sent
);
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
  state_t      state;
  logic [9:0]  len, issued, sent;
  logic [7:0]  b0, b1, n0, n1;
  logic [1:0]  cnt, left;
  logic [2:0]  occ;
  logic        inflight, flush_pend, pop, start, expired, last_rd;
  assign m_axis_tvalid = cnt != 2'd0;
  assign m_axis_tdata  = b0;
  assign m_axis_tlast  = m_axis_tvalid && sent == len - 10'd1;
  assign busy          = state != IDLE;
  assign pop           = m_axis_tvalid & m_axis_tready;
  assign occ           = {1'b0, cnt} + {2'b0, inflight};
  // a byte leaving this cycle frees its slot, keeping one byte per cycle with a 2-entry buffer
  assign fifo_rd_en    = state == STREAM && issued < len && occ < (pop ? 3'd3 : 3'd2);
  assign last_rd       = fifo_rd_en && issued == len - 10'd1;
  assign start         = fifo_count >= 11'(THRESHOLD) || ((flush_pend | flush_req) && fifo_count != 11'd0) || expired;
  always_comb begin
    left = cnt - {1'b0, pop};
    n0   = inflight && left == 2'd0 ? fifo_rd_data : pop ? b1 : b0;
    n1   = inflight && left == 2'd1 ? fifo_rd_data : b1;
  end
`ifdef CONSOLE_DMA_TIMEOUT_FLUSH_EN
  logic [31:0] timer;
  logic        partial;
  assign partial = fifo_count != 11'd0 && fifo_count < 11'(THRESHOLD);
  assign expired = state == IDLE && partial && timer >= 32'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk)
    timer <= (!rst_n || state != IDLE || !partial) ? 32'd0 : timer + 32'd1;
`else
  assign expired = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      len          <= '0;
      issued       <= '0;
      sent         <= '0;
      b0           <= '0;
      b1           <= '0;
      cnt          <= '0;
      inflight     <= 1'b0;
      flush_pend   <= 1'b0;
      packets_sent <= '0;
    end else begin
      b0       <= n0;
      b1       <= n1;
      cnt      <= left + {1'b0, inflight};
      inflight <= fifo_rd_en;
      if (pop) sent <= sent + 10'd1;
      if (fifo_rd_en) issued <= issued + 10'd1;
      if (pop && m_axis_tlast) packets_sent <= packets_sent + 16'd1;
      // in IDLE a request is either served right now or discarded (empty FIFO)
      flush_pend <= state == IDLE ? 1'b0 : flush_pend | flush_req;
      case (state)
        IDLE: if (start) begin
          state  <= STREAM;
          len    <= fifo_count > 11'(BURST_MAX) ? 10'(BURST_MAX) : fifo_count[9:0];
          issued <= '0;
          sent   <= '0;
        end
        STREAM: if (last_rd) state <= DRAIN;
        DRAIN:  if (pop && m_axis_tlast) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
